// File: rtl/carfield_ext_mst_arb.sv
// Round-robin, transaction-locked arbiter from NumReq requesters onto one master port, with
// outstanding-response tracking and response routing. Define CARFIELD_EXT_ARB_TIMEOUT_EN to add the LOCKED-stall watchdog.
module carfield_ext_mst_arb #(
  parameter int NumReq         = 2,
  parameter int DataWidth      = 64,
  parameter int MaxOutstanding = 8,
  parameter int TimeoutCycles  = 1024,
  localparam int SrcW          = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumReq-1:0]                  req_valid_i,
  output logic [NumReq-1:0]                  req_ready_o,
  input  logic [NumReq-1:0][DataWidth-1:0]   req_data_i,
  input  logic [NumReq-1:0]                  req_last_i,
  output logic                               mst_valid_o,
  input  logic                               mst_ready_i,
  output logic [DataWidth-1:0]               mst_data_o,
  output logic                               mst_last_o,
  output logic [SrcW-1:0]                    mst_src_o,
  input  logic                               rsp_valid_i,
  output logic                               rsp_ready_o,
  input  logic [SrcW-1:0]                    rsp_src_i,
  input  logic [DataWidth-1:0]               rsp_data_i,
  output logic [NumReq-1:0]                  rsp_valid_o,
  input  logic [NumReq-1:0]                  rsp_ready_i,
  output logic [DataWidth-1:0]               rsp_data_o,
  output logic                               busy_o,
  output logic                               err_timeout_o,
  output logic                               dbg_locked_o,
  output logic [7:0]                         dbg_outstanding_o
);

  // Handshakes: a beat transfers in a cycle where valid and ready are both high; a
  // producer holds valid and payload stable until that cycle.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [SrcW-1:0] owner_q, owner_d;
  logic [SrcW-1:0] ptr_q, ptr_d;
  logic [7:0]      outstanding_q, outstanding_d;

  logic [SrcW-1:0]      winner;
  logic                 any_valid;
  logic                 own_valid;
  logic                 own_last;
  logic [DataWidth-1:0] own_data;
  logic                 mst_hs;
  logic                 txn_done;
  logic                 rsp_hs;
  logic                 grant_ok;

  // Scan from the farthest offset down so the nearest valid index at/after ptr wins.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int off = NumReq - 1; off >= 0; off--) begin
      if (req_valid_i[(int'(ptr_q) + off) % NumReq]) begin
        winner    = SrcW'((int'(ptr_q) + off) % NumReq);
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (owner_q == SrcW'(i)) begin
        own_valid = req_valid_i[i];
        own_last  = req_last_i[i];
        own_data  = req_data_i[i];
      end
    end
  end

  assign mst_valid_o = (state_q == ST_LOCKED) && own_valid;
  assign mst_data_o  = own_data;
  assign mst_last_o  = own_last;
  assign mst_src_o   = owner_q;
  assign mst_hs      = mst_valid_o && mst_ready_i;
  assign txn_done    = mst_hs && mst_last_o;

  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      if ((state_q == ST_LOCKED) && (owner_q == SrcW'(i))) begin
        req_ready_o[i] = mst_ready_i;
      end
    end
  end

  // An index with no requester behind it is accepted and dropped.
  always_comb begin
    rsp_valid_o = '0;
    rsp_ready_o = 1'b1;
    for (int i = 0; i < NumReq; i++) begin
      if (rsp_src_i == SrcW'(i)) begin
        rsp_valid_o[i] = rsp_valid_i;
        rsp_ready_o    = rsp_ready_i[i];
      end
    end
  end

  assign rsp_data_o = rsp_data_i;
  assign rsp_hs     = rsp_valid_i && rsp_ready_o;

  always_comb begin
    outstanding_d = outstanding_q;
    if (txn_done && !rsp_hs) begin
      outstanding_d = outstanding_q + 8'd1;
    end else if (rsp_hs && !txn_done && (outstanding_q != 8'd0)) begin
      outstanding_d = outstanding_q - 8'd1;
    end
  end

  assign grant_ok = (outstanding_q < 8'(MaxOutstanding));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_valid && grant_ok) begin
          owner_d = winner;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (txn_done) begin
          ptr_d   = (owner_q == SrcW'(NumReq - 1)) ? '0 : owner_q + SrcW'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      owner_q       <= '0;
      ptr_q         <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign busy_o            = (state_q == ST_LOCKED) || (outstanding_q != 8'd0);
  assign dbg_locked_o      = (state_q == ST_LOCKED);
  assign dbg_outstanding_o = outstanding_q;

`ifdef CARFIELD_EXT_ARB_TIMEOUT_EN
  localparam int WdW = $clog2(TimeoutCycles + 1);

  logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
  logic           err_q, err_d;

  // The count saturates at the threshold; the flag only clears on reset.
  always_comb begin
    wd_cnt_d = '0;
    err_d    = err_q;
    if ((state_q == ST_LOCKED) && !mst_hs) begin
      wd_cnt_d = (wd_cnt_q == WdW'(TimeoutCycles)) ? wd_cnt_q : wd_cnt_q + WdW'(1);
      if (wd_cnt_d == WdW'(TimeoutCycles)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err_timeout_o = err_q;
`else
  assign err_timeout_o = 1'b0;
`endif

endmodule
